decode_stage: RTL and testbench
===============================

# decode_stage

Decode-stage datapath and ID/EX pipeline register for the five-stage RV32I pipeline. Takes the fetched instruction and the decoded control bundle, reads the register file, sign-extends the immediate, and registers everything into the Execute stage. It also owns the 32x32 register file and its write-back port. Sits between the IF/ID register and the Execute stage (ALU, branch compare).

## Interface
- No parameters; XLEN fixed at 32, 32 architectural registers.
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- InstrD  in  32  instruction from IF/ID register
- PCD, PCPlus4D  in  32 each  PC and PC+4 of the instruction in Decode
- RegWriteD, MemWriteD, BranchD, ALUSrcD  in  1 each  decoded control bits
- ResultSrcD  in  2  write-back select
- ALUControlD  in  3  ALU operation code
- ImmSrcD  in  2  immediate format select (used in Decode only, not forwarded)
- StallE  in  1  hold ID/EX register contents
- FlushE  in  1  load bubble into ID/EX register
- RegWriteW  in  1  write-back enable
- RdW  in  5  write-back destination
- ResultW  in  32  write-back data
- Rs1D, Rs2D  out  5 each  combinational source fields, for hazard unit
- RegWriteE, MemWriteE, BranchE, ALUSrcE  out  1 each  registered control
- ResultSrcE  out  2; ALUControlE  out  3  registered control
- RD1E, RD2E  out  32 each  registered operand values
- ImmExtE  out  32  registered extended immediate
- PCE, PCPlus4E  out  32 each  registered PCs
- RdE, Rs1E, Rs2E  out  5 each  registered register indices

## Operation
- Field decode: Rs1D=InstrD[19:15], Rs2D=InstrD[24:20], rd=InstrD[11:7].
- Immediate extend (combinational, on ImmSrcD): 00 I-type {20×i[31], i[31:20]}; 01 S-type {20×i[31], i[31:25], i[11:7]}; 10 B-type {19×i[31], i[31], i[7], i[30:25], i[11:8], 0}; 11 J-type {11×i[31], i[31], i[19:12], i[20], i[30:21], 0}.
- Register file: two combinational read ports, one write port. Write on rising edge when RegWriteW=1 and RdW≠0. x0 reads 0 always; writes to x0 discarded.
- Write-through bypass: if RegWriteW=1, RdW≠0 and RdW equals a read index, that port returns ResultW in the same cycle (same-cycle W→D handoff; no half-cycle clocking).
- ID/EX register update priority per rising edge: FlushE=1 → all E outputs 0 (bubble: RegWriteE=MemWriteE=BranchE=0); else StallE=1 → hold; else load D-stage values.
- FlushE and StallE both high: flush wins.
- Register-file write is independent of StallE/FlushE.

## Timing
- Decode-to-Execute latency: 1 cycle. Rs1D/Rs2D zero-latency combinational.
- Register write visible to same-cycle reads (bypass), and stored at the same edge.
- Reset (rst_n=0, asynchronous): all ID/EX outputs 0, all 31 registers x1..x31 cleared to 0. Assertion mid-stream discards in-flight E-stage instruction; first valid load on first rising edge after rst_n deasserts.
- No X propagation into E outputs: don't-care control inputs are registered as presented; bubbles are all-zero.

## Structure
- Shared package: opcode constants, ImmSrc encodings (IMM_I/S/B/J), ResultSrc and ALUControl encodings, XLEN=32, REG_ADDR_W=5; shared with ControlUnit.
- Sub-module: register_file (32x32, 2R1W, x0 hard-zero, write-through bypass, async reset). Immediate extender and ID/EX register stay inline.

## Test plan
- Reset: rst_n low mid-run with RegWriteD=1 loaded → all E outputs 0 immediately; read of x5 after release returns 0.
- Write/read: RegWriteW=1, RdW=5, ResultW=0xDEADBEEF; next cycle InstrD=add x1,x5,x0 → RD1E=0xDEADBEEF, RD2E=0 one cycle later.
- Bypass and x0: same cycle RegWriteW=1, RdW=3, ResultW=0x12345678 with InstrD reading x3 → RD1E=0x12345678; RdW=0 write of 0xFFFFFFFF → later x0 read returns 0.
- Immediates: InstrD=0xFFF00093 (addi x1,x0,-1, ImmSrcD=00) → ImmExtE=0xFFFFFFFF; beq with offset −8 (0xFE000CE3, ImmSrcD=10) → ImmExtE=0xFFFFFFF8; sw offset 12 → 0x0000000C.
- Stall/flush: StallE=1 for 2 cycles → E outputs unchanged; FlushE=1 with StallE=1 and RegWriteD=1 → RegWriteE=0, RdE=0, all data 0.
- Back-to-back: 4 consecutive instructions with StallE=FlushE=0 → each appears on E outputs exactly one cycle after being on D inputs, PCE tracking PCD.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: encodings, the ID/EX bundle and the immediate extender.
package decode_stage_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_e;
  typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10} result_src_e;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR  = 3'b011,
    ALU_XOR = 3'b100, ALU_SLT = 3'b101, ALU_SLL = 3'b110, ALU_SRL = 3'b111
  } alu_ctrl_e;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic                  branch;
    logic                  alu_src;
    logic [1:0]            result_src;
    logic [2:0]            alu_control;
    logic [XLEN-1:0]       rd1;
    logic [XLEN-1:0]       rd2;
    logic [XLEN-1:0]       imm_ext;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       pc_plus4;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
  } idex_t;

  // Opcode bits never contribute to the immediate, so only [31:7] is taken.
  function automatic logic [XLEN-1:0] imm_extend(input logic [31:7] i, input imm_src_e src);
    logic [XLEN-1:0] r;
    r = '0;
    case (src)
      IMM_I: r = {{20{i[31]}}, i[31:20]};
      IMM_S: r = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B: r = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      IMM_J: r = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/decode_stage_if.sv
// Decode-stage bus: D-stage inputs, write-back port, hazard fields and ID/EX outputs.
interface decode_stage_if;
  import decode_stage_pkg::*;

  logic [XLEN-1:0]       InstrD, PCD, PCPlus4D;
  logic                  RegWriteD, MemWriteD, BranchD, ALUSrcD;
  logic [1:0]            ResultSrcD;
  logic [2:0]            ALUControlD;
  logic [1:0]            ImmSrcD;
  logic                  StallE, FlushE;
  logic                  RegWriteW;
  logic [REG_ADDR_W-1:0] RdW;
  logic [XLEN-1:0]       ResultW;

  logic [REG_ADDR_W-1:0] Rs1D, Rs2D;
  logic                  RegWriteE, MemWriteE, BranchE, ALUSrcE;
  logic [1:0]            ResultSrcE;
  logic [2:0]            ALUControlE;
  logic [XLEN-1:0]       RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [REG_ADDR_W-1:0] RdE, Rs1E, Rs2E;

  modport master (
    output InstrD, PCD, PCPlus4D, RegWriteD, MemWriteD, BranchD, ALUSrcD,
           ResultSrcD, ALUControlD, ImmSrcD, StallE, FlushE, RegWriteW, RdW, ResultW,
    input  Rs1D, Rs2D, RegWriteE, MemWriteE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
           RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, Rs1E, Rs2E
  );

  modport slave (
    input  InstrD, PCD, PCPlus4D, RegWriteD, MemWriteD, BranchD, ALUSrcD,
           ResultSrcD, ALUControlD, ImmSrcD, StallE, FlushE, RegWriteW, RdW, ResultW,
    output Rs1D, Rs2D, RegWriteE, MemWriteE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
           RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, Rs1E, Rs2E
  );
endinterface

// File: rtl/decode_stage_register_file.sv
// 32x32 register file, two read ports, one write port; x0 hard-wired to zero.
module register_file
  import decode_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] ra1,
  input  logic [REG_ADDR_W-1:0] ra2,
  output logic [XLEN-1:0]       rd1,
  output logic [XLEN-1:0]       rd2,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] wa,
  input  logic [XLEN-1:0]       wd
);
  // x0 has no storage; entries start at x1.
  logic [NUM_REGS-1:1][XLEN-1:0] regs_q, regs_d;
  logic wr_en;

  assign wr_en = we && (wa != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wa] = wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  // Write-through lets W hand its result to D in the same cycle.
  assign rd1 = (ra1 == '0)              ? '0 :
               (wr_en && (wa == ra1))   ? wd : regs_q[ra1];
  assign rd2 = (ra2 == '0)              ? '0 :
               (wr_en && (wa == ra2))   ? wd : regs_q[ra2];
endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register read, immediate extend and the ID/EX pipeline register.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  decode_stage_if.slave bus
);
  logic [XLEN-1:0] rd1_d, rd2_d;
  idex_t           idex_load, idex_d, idex_q;

  assign bus.Rs1D = bus.InstrD[19:15];
  assign bus.Rs2D = bus.InstrD[24:20];

  register_file u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (bus.Rs1D),
    .ra2   (bus.Rs2D),
    .rd1   (rd1_d),
    .rd2   (rd2_d),
    .we    (bus.RegWriteW),
    .wa    (bus.RdW),
    .wd    (bus.ResultW)
  );

  always_comb begin
    idex_load             = '0;
    idex_load.reg_write   = bus.RegWriteD;
    idex_load.mem_write   = bus.MemWriteD;
    idex_load.branch      = bus.BranchD;
    idex_load.alu_src     = bus.ALUSrcD;
    idex_load.result_src  = bus.ResultSrcD;
    idex_load.alu_control = bus.ALUControlD;
    idex_load.rd1         = rd1_d;
    idex_load.rd2         = rd2_d;
    idex_load.imm_ext     = imm_extend(bus.InstrD[31:7], imm_src_e'(bus.ImmSrcD));
    idex_load.pc          = bus.PCD;
    idex_load.pc_plus4    = bus.PCPlus4D;
    idex_load.rd          = bus.InstrD[11:7];
    idex_load.rs1         = bus.Rs1D;
    idex_load.rs2         = bus.Rs2D;
  end

  // Flush beats stall: a bubble is an all-zero bundle.
  always_comb begin
    idex_d = idex_load;
    if (bus.FlushE)      idex_d = '0;
    else if (bus.StallE) idex_d = idex_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign bus.RegWriteE   = idex_q.reg_write;
  assign bus.MemWriteE   = idex_q.mem_write;
  assign bus.BranchE     = idex_q.branch;
  assign bus.ALUSrcE     = idex_q.alu_src;
  assign bus.ResultSrcE  = idex_q.result_src;
  assign bus.ALUControlE = idex_q.alu_control;
  assign bus.RD1E        = idex_q.rd1;
  assign bus.RD2E        = idex_q.rd2;
  assign bus.ImmExtE     = idex_q.imm_ext;
  assign bus.PCE         = idex_q.pc;
  assign bus.PCPlus4E    = idex_q.pc_plus4;
  assign bus.RdE         = idex_q.rd;
  assign bus.Rs1E        = idex_q.rs1;
  assign bus.Rs2E        = idex_q.rs2;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed D/W vectors, expected E bundles queued per cycle.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if bus ();
  decode_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    string       nm;
    int          cyc;
    logic [183:0] vec;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [183:0] act_vec();
    return {bus.RegWriteE, bus.MemWriteE, bus.BranchE, bus.ALUSrcE, bus.ResultSrcE,
            bus.ALUControlE, bus.RD1E, bus.RD2E, bus.ImmExtE, bus.PCE, bus.PCPlus4E,
            bus.RdE, bus.Rs1E, bus.Rs2E};
  endfunction

  task automatic chk(input string nm, input logic [183:0] act, input logic [183:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Expected E bundle for the values driven this cycle, due after the next rising edge.
  task automatic expect_e(input string nm, input logic [8:0] ctl,
                          input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                          input logic [31:0] pc, input logic [31:0] pc4,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    exp_t e;
    e.nm  = nm;
    e.cyc = cyc + 1;
    e.vec = {ctl, rd1, rd2, imm, pc, pc4, rd, rs1, rs2};
    q.push_back(e);
  endtask

  // ctl = {RegWrite, MemWrite, Branch, ALUSrc, ResultSrc[1:0], ALUControl[2:0]}
  task automatic cyc_d(input logic [31:0] instr, input logic [31:0] pc, input logic [1:0] imm_src,
                       input logic [8:0] ctl, input logic stall, input logic flush,
                       input logic wen, input logic [4:0] wrd, input logic [31:0] wdata);
    @(negedge clk);
    bus.InstrD   = instr;
    bus.PCD      = pc;
    bus.PCPlus4D = pc + 32'd4;
    bus.ImmSrcD  = imm_src;
    {bus.RegWriteD, bus.MemWriteD, bus.BranchD, bus.ALUSrcD, bus.ResultSrcD, bus.ALUControlD} = ctl;
    bus.StallE    = stall;
    bus.FlushE    = flush;
    bus.RegWriteW = wen;
    bus.RdW       = wrd;
    bus.ResultW   = wdata;
  endtask

  // Monitor: pops every entry due at this edge and compares against the E outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc != cyc) begin
          checks++;
          errors++;
          $display("FAIL %s missed at cycle %0d required cycle %0d", e.nm, cyc, e.cyc);
        end else begin
          chk(e.nm, act_vec(), e.vec);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  localparam logic [8:0] C_NONE = 9'b0_0_0_0_00_000;
  localparam logic [8:0] C_ADD  = 9'b1_0_0_0_00_000;
  localparam logic [8:0] C_ADDI = 9'b1_0_0_1_00_000;
  localparam logic [8:0] C_BEQ  = 9'b0_0_1_0_00_001;
  localparam logic [8:0] C_SW   = 9'b0_1_0_1_00_000;
  localparam logic [8:0] C_JAL  = 9'b1_0_0_0_10_000;

  initial begin
    bus.InstrD = '0; bus.PCD = '0; bus.PCPlus4D = '0; bus.ImmSrcD = '0;
    bus.RegWriteD = 0; bus.MemWriteD = 0; bus.BranchD = 0; bus.ALUSrcD = 0;
    bus.ResultSrcD = '0; bus.ALUControlD = '0; bus.StallE = 0; bus.FlushE = 0;
    bus.RegWriteW = 0; bus.RdW = '0; bus.ResultW = '0;

    @(posedge clk); #1;
    chk("reset_state", act_vec(), '0);
    @(negedge clk); rst_n = 1'b1;

    cyc_d(32'h0, 32'h0FC, 2'b00, C_NONE, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    expect_e("first_load", C_NONE, 0, 0, 0, 32'h0FC, 32'h100, 0, 0, 0);
    cyc_d(32'h000280B3, 32'h100, 2'b00, C_ADD, 0, 0, 0, 0, 0);
    expect_e("read_x5", C_ADD, 32'hDEADBEEF, 0, 0, 32'h100, 32'h104, 1, 5, 0);
    cyc_d(32'h00018133, 32'h104, 2'b00, C_ADD, 0, 0, 1, 5'd3, 32'h12345678);
    #1 chk("rs_fields", {bus.Rs1D, bus.Rs2D}, {5'd3, 5'd0});
    expect_e("bypass_x3", C_ADD, 32'h12345678, 0, 0, 32'h104, 32'h108, 2, 3, 0);
    cyc_d(32'h00000233, 32'h108, 2'b00, C_ADD, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
    expect_e("x0_no_bypass", C_ADD, 0, 0, 0, 32'h108, 32'h10C, 4, 0, 0);
    cyc_d(32'h000180B3, 32'h10C, 2'b00, C_ADD, 0, 0, 0, 0, 0);
    expect_e("x3_stored", C_ADD, 32'h12345678, 0, 0, 32'h10C, 32'h110, 1, 3, 0);
    cyc_d(32'hFFF00093, 32'h110, 2'b00, C_ADDI, 0, 0, 0, 0, 0);
    expect_e("imm_i_neg1", C_ADDI, 0, 0, 32'hFFFFFFFF, 32'h110, 32'h114, 1, 0, 31);
    cyc_d(32'hFE000CE3, 32'h114, 2'b10, C_BEQ, 0, 0, 0, 0, 0);
    expect_e("imm_b_neg8", C_BEQ, 0, 0, 32'hFFFFFFF8, 32'h114, 32'h118, 25, 0, 0);
    cyc_d(32'h0020A623, 32'h118, 2'b01, C_SW, 0, 0, 1, 5'd2, 32'hA5A5A5A5);
    expect_e("imm_s_12", C_SW, 0, 32'hA5A5A5A5, 32'h0000000C, 32'h118, 32'h11C, 12, 1, 2);
    cyc_d(32'hFFDFF06F, 32'h11C, 2'b11, C_JAL, 0, 0, 0, 0, 0);
    expect_e("imm_j_neg4", C_JAL, 0, 0, 32'hFFFFFFFC, 32'h11C, 32'h120, 0, 31, 29);

    cyc_d(32'h000280B3, 32'h200, 2'b00, C_ADD, 1, 0, 1, 5'd7, 32'h00000077);
    expect_e("stall_1", C_JAL, 0, 0, 32'hFFFFFFFC, 32'h11C, 32'h120, 0, 31, 29);
    cyc_d(32'h00018133, 32'h204, 2'b00, C_ADD, 1, 0, 0, 0, 0);
    expect_e("stall_2", C_JAL, 0, 0, 32'hFFFFFFFC, 32'h11C, 32'h120, 0, 31, 29);
    cyc_d(32'h000280B3, 32'h208, 2'b00, C_ADD, 1, 1, 0, 0, 0);
    expect_e("flush_over_stall", C_NONE, 0, 0, 0, 0, 0, 0, 0, 0);

    cyc_d(32'h000380B3, 32'h300, 2'b00, C_ADD, 0, 0, 0, 0, 0);
    expect_e("b2b_0_x7", C_ADD, 32'h00000077, 0, 0, 32'h300, 32'h304, 1, 7, 0);
    cyc_d(32'h00328133, 32'h304, 2'b00, C_ADD, 0, 0, 0, 0, 0);
    expect_e("b2b_1", C_ADD, 32'hDEADBEEF, 32'h12345678, 32'h3, 32'h304, 32'h308, 2, 5, 3);
    cyc_d(32'hFFF00093, 32'h308, 2'b00, C_ADDI, 0, 0, 0, 0, 0);
    expect_e("b2b_2", C_ADDI, 0, 0, 32'hFFFFFFFF, 32'h308, 32'h30C, 1, 0, 31);
    cyc_d(32'h00000233, 32'h30C, 2'b00, C_ADD, 0, 0, 0, 0, 0);
    expect_e("b2b_3", C_ADD, 0, 0, 0, 32'h30C, 32'h310, 4, 0, 0);

    // Load something live, then reset asynchronously between edges.
    cyc_d(32'h000280B3, 32'h400, 2'b00, C_ADD, 0, 0, 0, 0, 0);
    expect_e("pre_reset_load", C_ADD, 32'hDEADBEEF, 0, 0, 32'h400, 32'h404, 1, 5, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 chk("async_reset", act_vec(), '0);
    @(negedge clk); rst_n = 1'b1;
    cyc_d(32'h000280B3, 32'h404, 2'b00, C_ADD, 0, 0, 0, 0, 0);
    expect_e("x5_cleared", C_ADD, 0, 0, 0, 32'h404, 32'h408, 1, 5, 0);

    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
